// File: rtl/vector_alu_seq_if.sv
// vector_alu_seq_if: operand/command and result bundle between the VRF wrapper and the vector ALU
interface vector_alu_seq_if #(
  parameter int DataWidth = 128
);
  logic                 start_i;
  logic [2:0]           op_i;
  logic [1:0]           sew_i;
  logic                 sat_i;
  logic [DataWidth-1:0] vs1_i;
  logic [DataWidth-1:0] vs2_i;
  logic [DataWidth-1:0] vs3_i;
  logic                 busy_o;
  logic [DataWidth-1:0] result_o;
  logic                 result_valid_o;
  logic                 sat_o;
  modport master (
    output start_i, op_i, sew_i, sat_i, vs1_i, vs2_i, vs3_i,
    input  busy_o, result_o, result_valid_o, sat_o
  );
  modport slave (
    input  start_i, op_i, sew_i, sat_i, vs1_i, vs2_i, vs3_i,
    output busy_o, result_o, result_valid_o, sat_o
  );
endinterface

// File: rtl/vector_alu_seq.sv
// vector_alu_seq: SEW-aware vector ALU, one LaneWidth chunk per cycle; saturating ADD/SUB under VECTOR_ALU_SATURATE_EN
module vector_alu_seq #(
  parameter int DataWidth = 128,
  parameter int LaneWidth = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  vector_alu_seq_if.slave bus
);
  localparam int NumChunks = DataWidth / LaneWidth;
  localparam int CW = NumChunks > 1 ? $clog2(NumChunks) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           op;
  logic [1:0]           sew;
  logic                 sat_en;
  logic [DataWidth-1:0] a, b, c;
  logic [LaneWidth-1:0] lane_res;
  logic                 lane_sat;
  logic [32:0]          w_res;
  // one element of width w held zero-extended in 32 bits; returns {clamped, result}
  function automatic logic [32:0] elem(input logic [2:0] o, input logic s, input int w,
                                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [31:0] m, raw, res;
    logic [32:0] sum;
    logic        ss;
    m   = 32'hFFFF_FFFF >> (32 - w);
    sum = {1'b0, x} + {1'b0, y};
    raw = o == 3'd0 ? sum[31:0] : o == 3'd1 ? x - y : o == 3'd2 ? x & y : o == 3'd3 ? x | y :
          o == 3'd4 ? x ^ y : o == 3'd5 ? x * y + z : o == 3'd6 ? (x < y ? x : y) : (x > y ? x : y);
    ss  = s & ((o == 3'd0 & sum > {1'b0, m}) | (o == 3'd1 & y > x));
    res = ss ? (o == 3'd0 ? m : 32'd0) : raw & m;
    return {ss, res};
  endfunction
  function automatic logic [32:0] word_op(input logic [2:0] o, input logic [1:0] sw, input logic s,
                                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [32:0] t;
    logic [31:0] r8, r16, r32;
    logic        s8, s16, s32;
    s8 = 1'b0;
    s16 = 1'b0;
    r8 = '0;
    r16 = '0;
    for (int i = 0; i < 4; i++) begin
      t = elem(o, s, 8, {24'b0, x[8*i +: 8]}, {24'b0, y[8*i +: 8]}, {24'b0, z[8*i +: 8]});
      r8[8*i +: 8] = t[7:0];
      s8 = s8 | t[32];
    end
    for (int i = 0; i < 2; i++) begin
      t = elem(o, s, 16, {16'b0, x[16*i +: 16]}, {16'b0, y[16*i +: 16]}, {16'b0, z[16*i +: 16]});
      r16[16*i +: 16] = t[15:0];
      s16 = s16 | t[32];
    end
    t = elem(o, s, 32, x, y, z);
    r32 = t[31:0];
    s32 = t[32];
    return sw == 2'd0 ? {s8, r8} : sw == 2'd1 ? {s16, r16} : {s32, r32};
  endfunction
  always_comb begin
    lane_res = '0;
    lane_sat = 1'b0;
    w_res = '0;
    for (int j = 0; j < LaneWidth / 32; j++) begin
      w_res = word_op(op, sew, sat_en, a[32*j +: 32], b[32*j +: 32], c[32*j +: 32]);
      lane_res[32*j +: 32] = w_res[31:0];
      lane_sat = lane_sat | w_res[32];
    end
  end
  // operands shift down one lane per EXEC cycle so the datapath always works on the low chunk
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      bus.result_o <= '0;
      bus.result_valid_o <= 1'b0;
      bus.busy_o <= 1'b0;
    end else begin
      bus.result_valid_o <= state == DONE;
      case (state)
        IDLE: if (bus.start_i) begin
          state <= EXEC;
          cnt <= '0;
          bus.busy_o <= 1'b1;
          op <= bus.op_i;
          sew <= bus.sew_i;
          a <= bus.vs1_i;
          b <= bus.vs2_i;
          c <= bus.vs3_i;
        end
        EXEC: begin
          for (int k = 0; k < NumChunks; k++)
            if (cnt == CW'(k)) bus.result_o[k*LaneWidth +: LaneWidth] <= lane_res;
          a <= a >> LaneWidth;
          b <= b >> LaneWidth;
          c <= c >> LaneWidth;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NumChunks - 1)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          bus.busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef VECTOR_ALU_SATURATE_EN
  always_ff @(posedge clk_i)
    if (rst_i) bus.sat_o <= 1'b0;
    else if (state == IDLE && bus.start_i) begin
      bus.sat_o <= 1'b0;
      sat_en <= bus.sat_i;
    end else if (state == EXEC) bus.sat_o <= bus.sat_o | lane_sat;
`else
  // sat_en is constant 0 here, so lane_sat folds to a constant 0
  assign sat_en = 1'b0;
  assign bus.sat_o = lane_sat;
`endif
endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: scoreboard bench for vector_alu_seq with a per-element reference model
module tb_vector_alu_seq;
  localparam int DW = 128;
`ifdef VECTOR_ALU_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif
  typedef struct {
    logic [DW-1:0] r;
    logic          s;
    int            c;
    string         n;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  vector_alu_seq_if #(.DataWidth(DW)) bus ();
  vector_alu_seq #(.DataWidth(DW), .LaneWidth(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  task automatic check(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic logic [DW:0] model(input logic [2:0] op, input logic [1:0] sew, input logic sat,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    int w;
    longint unsigned m, x, y, z, v;
    logic [DW-1:0] r;
    logic s;
    w = sew == 2'd0 ? 8 : sew == 2'd1 ? 16 : 32;
    m = (64'd1 << w) - 1;
    r = '0;
    s = 1'b0;
    for (int i = 0; i < DW / w; i++) begin
      x = 64'(a >> (i * w)) & m;
      y = 64'(b >> (i * w)) & m;
      z = 64'(c >> (i * w)) & m;
      case (op)
        3'd0: begin
          v = x + y;
          if (sat && SatEn && v > m) begin v = m; s = 1'b1; end
        end
        3'd1: begin
          v = x - y;
          if (sat && SatEn && y > x) begin v = 0; s = 1'b1; end
        end
        3'd2: v = x & y;
        3'd3: v = x | y;
        3'd4: v = x ^ y;
        3'd5: v = x * y + z;
        3'd6: v = x < y ? x : y;
        default: v = x > y ? x : y;
      endcase
      r = r | (DW'(v & m) << (i * w));
    end
    return {s, r};
  endfunction
  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic drive(input logic [2:0] op, input logic [1:0] sew, input logic sat,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    bus.op_i = op;
    bus.sew_i = sew;
    bus.sat_i = sat;
    bus.vs1_i = a;
    bus.vs2_i = b;
    bus.vs3_i = c;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL timeout: %0d results outstanding, want 0", q.size());
      q.delete();
    end
  endtask
  task automatic issue(input string n, input logic [2:0] op, input logic [1:0] sew, input logic sat,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input logic [DW-1:0] er, input logic es);
    @(negedge clk);
    drive(op, sew, sat, a, b, c);
    bus.start_i = 1'b1;
    q.push_back('{er, es, cyc + 6, n});
    @(negedge clk);
    bus.start_i = 1'b0;
    drive(3'($urandom), 2'($urandom), 1'($urandom), rnd(), rnd(), rnd());
    drain();
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.result_valid_o === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_valid: got pulse at cycle %0d want none", cyc);
        end else begin
          e = q.pop_front();
          check({e.n, "_result"}, bus.result_o, e.r);
          check({e.n, "_sat"}, DW'(bus.sat_o), DW'(e.s));
          check({e.n, "_cycle"}, DW'(cyc), DW'(e.c));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [DW:0] m;
    logic [2:0] op;
    logic [1:0] sew;
    logic sat;
    logic [DW-1:0] a, b, c;
    bus.start_i = 1'b0;
    drive(3'd0, 2'd0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_busy", DW'(bus.busy_o), '0);
    check("rst_valid", DW'(bus.result_valid_o), '0);
    check("rst_result", bus.result_o, '0);
    check("rst_sat", DW'(bus.sat_o), '0);
    rst = 1'b0;
    @(negedge clk);
    drive(3'd0, 2'd2, 1'b0, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, '0);
    bus.start_i = 1'b1;
    q.push_back('{'0, 1'b0, cyc + 6, "add32_wrap"});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      check($sformatf("busy_exec%0d", i), DW'(bus.busy_o), DW'(1));
    end
    @(negedge clk);
    check("busy_after", DW'(bus.busy_o), '0);
    drain();
    issue("add8_nocarry", 3'd0, 2'd0, 1'b0, {16{8'h80}}, {16{8'h80}}, '0, '0, 1'b0);
    issue("add16_nocarry", 3'd0, 2'd1, 1'b0, {8{16'h8000}}, {8{16'h8000}}, '0, '0, 1'b0);
    issue("macc16", 3'd5, 2'd1, 1'b0, {8{16'h0003}}, {8{16'h0004}}, {8{16'h0005}}, {8{16'h0011}}, 1'b0);
    issue("macc16_trunc", 3'd5, 2'd1, 1'b0, {8{16'h0100}}, {8{16'h0100}}, {8{16'h0005}}, {8{16'h0005}}, 1'b0);
    @(negedge clk);
    drive(3'd4, 2'd2, 1'b0, {4{32'h0F0F_0F0F}}, {4{32'h00FF_00FF}}, '0);
    bus.start_i = 1'b1;
    q.push_back('{{4{32'h0FF0_0FF0}}, 1'b0, cyc + 6, "held_first"});
    @(negedge clk);
    drive(3'd1, 2'd0, 1'b0, {16{8'h05}}, {16{8'h07}}, '0);
    q.push_back('{{16{8'hFE}}, 1'b0, cyc + 11, "held_second"});
    repeat (6) @(negedge clk);
    bus.start_i = 1'b0;
    drive(3'($urandom), 2'($urandom), 1'($urandom), rnd(), rnd(), rnd());
    drain();
    @(negedge clk);
    drive(3'd0, 2'd2, 1'b0, {4{32'h1111_1111}}, {4{32'h2222_2222}}, '0);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", DW'(bus.busy_o), '0);
    check("abort_result", bus.result_o, '0);
    check("abort_valid", DW'(bus.result_valid_o), '0);
    repeat (8) @(negedge clk);
    issue("add_after_abort", 3'd0, 2'd2, 1'b0, {4{32'h1111_1111}}, {4{32'h2222_2222}}, '0,
          {4{32'h3333_3333}}, 1'b0);
    issue("add8_sat", 3'd0, 2'd0, 1'b1, {16{8'hF0}}, {16{8'h20}}, '0,
          SatEn ? {16{8'hFF}} : {16{8'h10}}, SatEn);
    issue("sub8_sat", 3'd1, 2'd0, 1'b1, {16{8'h10}}, {16{8'h20}}, '0,
          SatEn ? {16{8'h00}} : {16{8'hF0}}, SatEn);
    issue("add8_nosat", 3'd0, 2'd0, 1'b0, {16{8'hF0}}, {16{8'h20}}, '0, {16{8'h10}}, 1'b0);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      sew = 2'($urandom);
      sat = 1'($urandom);
      a = rnd();
      b = rnd();
      c = rnd();
      if (i % 4 == 0) b = ~a;
      m = model(op, sew, sat, a, b, c);
      issue($sformatf("rand%0d", i), op, sew, sat, a, b, c, m[DW-1:0], m[DW]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
